// File: rtl/sysver_boot_reader_if.sv
// AXI4-lite read-only channel bundle between the boot reader and the version core.
interface sysver_boot_reader_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 32
);
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;

  modport master (
    output araddr, arprot, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arprot, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/sysver_boot_reader.sv
// Reads FPGA_VER, FPGA_VER_BUILD and BOARD from the version core over AXI4-lite
// and holds them as stable parallel outputs for bus-less consumers.
module sysver_boot_reader #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH = 4,
  parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_BASE_ADDR        = 0,
  parameter int unsigned C_AUTO_START       = 1,
  parameter int unsigned C_TIMEOUT          = 255
) (
  input  logic                          m_axi_aclk,
  input  logic                          m_axi_areset,
  input  logic                          start,
  output logic                          busy,
  output logic                          done,
  output logic                          valid,
  output logic                          error,
  output logic                          timeout,
  output logic [C_M_AXI_DATA_WIDTH-1:0] fpga_ver,
  output logic [C_M_AXI_DATA_WIDTH-1:0] fpga_ver_build,
  output logic [C_M_AXI_DATA_WIDTH-1:0] board_word,
  sysver_boot_reader_if.master          m_axi
);

  localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
  localparam int unsigned TW = 16;
  localparam logic [TW-1:0] TMO_LIMIT = TW'(C_TIMEOUT);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, NEXT} state_t;

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic          auto_q, auto_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tick;
  logic          busy_d, done_d, valid_d, error_d, timeout_d;
  logic          arvalid_q, arvalid_d;
  logic          rready_q, rready_d;
  logic [AW-1:0] araddr_q, araddr_d;
  logic [DW-1:0] ver_d, build_d, board_d;
  logic          ar_hs, r_hs;

  function automatic logic [AW-1:0] addr_of(input logic [1:0] i);
    return AW'(C_BASE_ADDR + 32'(i) * 32'd4);
  endfunction

  assign ar_hs = arvalid_q & m_axi.arready;
  assign r_hs  = rready_q & m_axi.rvalid;

  assign m_axi.araddr  = araddr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    auto_d    = auto_q;
    tmo_d     = tmo_q;
    tick      = 1'b0;
    busy_d    = busy;
    done_d    = 1'b0;
    valid_d   = valid;
    error_d   = error;
    timeout_d = timeout;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    araddr_d  = araddr_q;
    ver_d     = fpga_ver;
    build_d   = fpga_ver_build;
    board_d   = board_word;

    case (state_q)
      IDLE: begin
        // a start coinciding with the done pulse is deliberately dropped
        if (auto_q || (start && !done)) begin
          state_d   = ADDR;
          idx_d     = 2'd0;
          auto_d    = 1'b0;
          tmo_d     = '0;
          busy_d    = 1'b1;
          valid_d   = 1'b0;
          error_d   = 1'b0;
          timeout_d = 1'b0;
          arvalid_d = 1'b1;
          araddr_d  = addr_of(2'd0);
        end
      end
      ADDR: begin
        if (ar_hs) begin
          state_d   = DATA;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          tmo_d     = '0;
        end else begin
          tick = 1'b1;
        end
      end
      DATA: begin
        if (r_hs) begin
          rready_d = 1'b0;
          tmo_d    = '0;
          if (m_axi.rresp == 2'b00) begin
            state_d = NEXT;
            case (idx_q)
              2'd0:    ver_d   = m_axi.rdata;
              2'd1:    build_d = m_axi.rdata;
              default: board_d = m_axi.rdata;
            endcase
          end else begin
            state_d = IDLE;
            error_d = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          tick = 1'b1;
        end
      end
      NEXT: begin
        if (idx_q == 2'd2) begin
          state_d = IDLE;
          valid_d = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d   = ADDR;
          idx_d     = idx_q + 2'd1;
          arvalid_d = 1'b1;
          araddr_d  = addr_of(idx_q + 2'd1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Watchdog only flags; the handshake is never withdrawn
    if (tick && (tmo_q != TMO_LIMIT)) begin
      tmo_d = tmo_q + TW'(1);
      if (tmo_d == TMO_LIMIT) begin
        timeout_d = 1'b1;
        error_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      state_q        <= IDLE;
      idx_q          <= 2'd0;
      auto_q         <= 1'(C_AUTO_START != 0);
      tmo_q          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      valid          <= 1'b0;
      error          <= 1'b0;
      timeout        <= 1'b0;
      arvalid_q      <= 1'b0;
      rready_q       <= 1'b0;
      araddr_q       <= '0;
      fpga_ver       <= '0;
      fpga_ver_build <= '0;
      board_word     <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      auto_q         <= auto_d;
      tmo_q          <= tmo_d;
      busy           <= busy_d;
      done           <= done_d;
      valid          <= valid_d;
      error          <= error_d;
      timeout        <= timeout_d;
      arvalid_q      <= arvalid_d;
      rready_q       <= rready_d;
      araddr_q       <= araddr_d;
      fpga_ver       <= ver_d;
      fpga_ver_build <= build_d;
      board_word     <= board_d;
    end
  end

endmodule

// File: tb/tb_sysver_boot_reader.sv
// Directed bench for sysver_boot_reader with a small configurable AXI-lite slave.
module tb_sysver_boot_reader;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;

  logic          m_axi_aclk   = 1'b0;
  logic          m_axi_areset = 1'b1;
  logic          start        = 1'b0;
  logic          busy, done, valid, error, timeout;
  logic [DW-1:0] fpga_ver, fpga_ver_build, board_word;

  sysver_boot_reader_if #(.AW(AW), .DW(DW)) axi ();

  sysver_boot_reader #(
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(DW),
    .C_BASE_ADDR(0),
    .C_AUTO_START(1),
    .C_TIMEOUT(255)
  ) dut (
    .m_axi_aclk    (m_axi_aclk),
    .m_axi_areset  (m_axi_areset),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .valid         (valid),
    .error         (error),
    .timeout       (timeout),
    .fpga_ver      (fpga_ver),
    .fpga_ver_build(fpga_ver_build),
    .board_word    (board_word),
    .m_axi         (axi)
  );

  always #5 m_axi_aclk = ~m_axi_aclk;

  // Slave model: arready one cycle after arvalid, rvalid r_delay cycles after the AR handshake
  logic [31:0] mem [0:3];
  int          err_idx = -1;
  bit          ar_stall = 1'b0;
  int          r_delay = 0;
  int          r_wait;

  always @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      axi.arready <= 1'b0;
      axi.rvalid  <= 1'b0;
      axi.rdata   <= '0;
      axi.rresp   <= 2'b00;
      r_wait      <= 0;
    end else begin
      axi.arready <= 1'b0;
      if (axi.arvalid && !axi.arready && !ar_stall) axi.arready <= 1'b1;
      if (axi.arvalid && axi.arready) begin
        axi.rdata <= mem[axi.araddr[3:2]];
        axi.rresp <= (int'(axi.araddr[3:2]) == err_idx) ? 2'b10 : 2'b00;
        if (r_delay == 0) axi.rvalid <= 1'b1;
        else              r_wait     <= r_delay;
      end else if (r_wait != 0) begin
        if (r_wait == 1) axi.rvalid <= 1'b1;
        r_wait <= r_wait - 1;
      end
      if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
    end
  end

  // Protocol monitors sampled on the falling edge
  bit          overlap_seen = 1'b0;
  bit          ar_unstable  = 1'b0;
  bit          prev_pend    = 1'b0;
  logic [AW-1:0] prev_addr  = '0;
  int          done_cnt     = 0;

  always @(negedge m_axi_aclk) begin
    if (m_axi_areset) begin
      prev_pend <= 1'b0;
    end else begin
      if (axi.arvalid && axi.rready) overlap_seen <= 1'b1;
      if (prev_pend && (!axi.arvalid || axi.araddr != prev_addr)) ar_unstable <= 1'b1;
      prev_pend <= axi.arvalid && !axi.arready;
      prev_addr <= axi.araddr;
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge m_axi_aclk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    do begin
      @(posedge m_axi_aclk); #1;
      n++;
    end while (!done && n < max);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d0;
    mem[0] = 32'h0000_0001; mem[1] = 32'h0000_002A; mem[2] = 32'h0003_0002; mem[3] = '0;

    // Reset values
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_arvalid", 32'(axi.arvalid), 32'd0);
    check("rst_arprot", 32'(axi.arprot), 32'd0);
    check("rst_ver", fpga_ver, 32'd0);

    // 1: auto start after reset release
    repeat (3) @(negedge m_axi_aclk);
    m_axi_areset = 1'b0;
    @(posedge m_axi_aclk); #1;
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_araddr", 32'(axi.araddr), 32'd0);
    wait_done(50, n);
    check("t1_latency", n, 12);
    check("t1_done", 32'(done), 32'd1);
    check("t1_ver", fpga_ver, 32'h0000_0001);
    check("t1_build", fpga_ver_build, 32'h0000_002A);
    check("t1_board", board_word, 32'h0003_0002);
    check("t1_valid", 32'(valid), 32'd1);
    check("t1_error", 32'(error), 32'd0);

    // 2: slave error on word 1
    mem[0] = 32'h0000_0011; mem[1] = 32'h0000_DEAD; mem[2] = 32'h0000_0077;
    err_idx = 1;
    @(posedge m_axi_aclk); #1;
    pulse_start();
    wait_done(50, n);
    check("t2_latency", n, 7);
    check("t2_error", 32'(error), 32'd1);
    check("t2_valid", 32'(valid), 32'd0);
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_ver", fpga_ver, 32'h0000_0011);
    check("t2_build_kept", fpga_ver_build, 32'h0000_002A);
    check("t2_board_kept", board_word, 32'h0003_0002);
    err_idx = -1;
    @(posedge m_axi_aclk); #1;
    pulse_start();
    check("t2_err_clr", 32'(error), 32'd0);
    check("t2_busy2", 32'(busy), 32'd1);
    wait_done(50, n);
    check("t2_valid2", 32'(valid), 32'd1);
    check("t2_build2", fpga_ver_build, 32'h0000_DEAD);
    check("t2_board2", board_word, 32'h0000_0077);

    // 3: address stall beyond the timeout
    mem[0] = 32'h0000_0001; mem[1] = 32'h0000_002A; mem[2] = 32'h0003_0002;
    ar_stall = 1'b1;
    @(posedge m_axi_aclk); #1;
    pulse_start();
    repeat (254) @(posedge m_axi_aclk); #1;
    check("t3_tmo_early", 32'(timeout), 32'd0);
    @(posedge m_axi_aclk); #1;
    check("t3_tmo", 32'(timeout), 32'd1);
    check("t3_err", 32'(error), 32'd1);
    check("t3_arvalid", 32'(axi.arvalid), 32'd1);
    check("t3_araddr", 32'(axi.araddr), 32'd0);
    repeat (45) @(posedge m_axi_aclk); #1;
    check("t3_arvalid_late", 32'(axi.arvalid), 32'd1);
    ar_stall = 1'b0;
    wait_done(100, n);
    check("t3_done", 32'(done), 32'd1);
    check("t3_valid", 32'(valid), 32'd1);
    check("t3_tmo_sticky", 32'(timeout), 32'd1);
    check("t3_err_sticky", 32'(error), 32'd1);
    check("t3_ar_stable", 32'(ar_unstable), 32'd0);

    // 4: read-data backpressure
    mem[0] = 32'hCAFE_0001; mem[1] = 32'h1234_5678; mem[2] = 32'h0BAD_0F00;
    r_delay = 5;
    @(posedge m_axi_aclk); #1;
    pulse_start();
    check("t4_tmo_clr", 32'(timeout), 32'd0);
    wait_done(200, n);
    check("t4_latency", n, 27);
    check("t4_ver", fpga_ver, 32'hCAFE_0001);
    check("t4_build", fpga_ver_build, 32'h1234_5678);
    check("t4_board", board_word, 32'h0BAD_0F00);
    check("t4_valid", 32'(valid), 32'd1);
    check("t4_no_overlap", 32'(overlap_seen), 32'd0);

    // 5: start while busy and in the done cycle
    r_delay = 0;
    @(posedge m_axi_aclk); #1;
    d0 = done_cnt;
    pulse_start();
    repeat (2) @(posedge m_axi_aclk); #1;
    pulse_start();
    check("t5_busy", 32'(busy), 32'd1);
    repeat (8) @(posedge m_axi_aclk); #1;
    check("t5_no_done_e11", 32'(done), 32'd0);
    @(posedge m_axi_aclk); #1;
    check("t5_done_e12", 32'(done), 32'd1);
    pulse_start();
    check("t5_ignored", 32'(busy), 32'd0);
    check("t5_one_seq", done_cnt, d0 + 1);
    pulse_start();
    check("t5_second", 32'(busy), 32'd1);
    wait_done(50, n);
    check("t5_latency", n, 12);
    @(negedge m_axi_aclk); #1;
    check("t5_two_seq", done_cnt, d0 + 2);

    // 6: reset in DATA of word 1
    @(posedge m_axi_aclk); #1;
    pulse_start();
    repeat (6) @(posedge m_axi_aclk); #1;
    check("t6_in_data", 32'(axi.rready), 32'd1);
    check("t6_addr_w1", 32'(axi.araddr), 32'd4);
    m_axi_areset = 1'b1;
    #1;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_rready", 32'(axi.rready), 32'd0);
    check("t6_arvalid", 32'(axi.arvalid), 32'd0);
    check("t6_araddr", 32'(axi.araddr), 32'd0);
    check("t6_valid", 32'(valid), 32'd0);
    check("t6_ver", fpga_ver, 32'd0);
    check("t6_board", board_word, 32'd0);
    @(negedge m_axi_aclk);
    m_axi_areset = 1'b0;
    @(posedge m_axi_aclk); #1;
    check("t6_auto", 32'(busy), 32'd1);
    wait_done(50, n);
    check("t6_latency", n, 12);
    check("t6_valid2", 32'(valid), 32'd1);
    check("t6_error2", 32'(error), 32'd0);
    check("t6_ver2", fpga_ver, 32'hCAFE_0001);
    check("t6_build2", fpga_ver_build, 32'h1234_5678);
    check("t6_board2", board_word, 32'h0BAD_0F00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
